// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES decryption types, constants and GF(2^8) helpers
// Contents: state_t (FSM states), NR (round count), INV_SBOX (inverse S-box),
//           xtime, gmul09/0b/0d/0e, inv_shift_rows, inv_mix_column.
// State bytes are column-major: byte i = r + 4*c lives at bits [127-8*i -: 8].
package aes_pkg;

   typedef enum logic {S_IDLE, S_RUN} state_t;

   localparam int NR = 10;

   localparam logic [0:255][7:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   // 9, 11, 13, 14 expressed as sums of b, 2b, 4b, 8b from one xtime chain.
   function automatic logic [7:0] gmul09(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
      return x8 ^ b;
   endfunction

   function automatic logic [7:0] gmul0b(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
      return x8 ^ x2 ^ b;
   endfunction

   function automatic logic [7:0] gmul0d(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
      return x8 ^ x4 ^ b;
   endfunction

   function automatic logic [7:0] gmul0e(input logic [7:0] b);
      logic [7:0] x2, x4, x8;
      x2 = xtime(b); x4 = xtime(x2); x8 = xtime(x4);
      return x8 ^ x4 ^ x2;
   endfunction

   // Row r is rotated right by r: out[r][c] = in[r][(c - r) mod 4].
   function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
      logic [127:0] o;
      o = '0;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+4-r)%4)) -: 8];
      return o;
   endfunction

   function automatic logic [31:0] inv_mix_column(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      {a0, a1, a2, a3} = col;
      return {gmul0e(a0) ^ gmul0b(a1) ^ gmul0d(a2) ^ gmul09(a3),
              gmul09(a0) ^ gmul0e(a1) ^ gmul0b(a2) ^ gmul0d(a3),
              gmul0d(a0) ^ gmul09(a1) ^ gmul0e(a2) ^ gmul0b(a3),
              gmul0b(a0) ^ gmul0d(a1) ^ gmul09(a2) ^ gmul0e(a3)};
   endfunction

endpackage

// File: rtl/aes_inv_cipher_if.sv
// rtl/aes_inv_cipher_if.sv - request/result and key-store signals of the inverse cipher
// Signals: start, iBlock (request), round/roundKey (key-store lookup),
//          oBlock, idle, done (result/status).
// Modports: master drives requests and serves keys; slave is the cipher.
interface aes_inv_cipher_if;
   logic         start;
   logic [127:0] iBlock;
   logic [3:0]   round;
   logic [127:0] roundKey;
   logic [127:0] oBlock;
   logic         idle;
   logic         done;

   modport master (output start, iBlock, roundKey, input round, oBlock, idle, done);
   modport slave  (input start, iBlock, roundKey, output round, oBlock, idle, done);
endinterface

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - one combinational AES inverse round
// Ports: state (in 128), roundKey (in 128), last (in 1, skip InvMixColumns),
//        next (out 128).
module aes_inv_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] roundKey,
   input  logic         last,
   output logic [127:0] next
);

   logic [127:0] sr, sb, ark, mixed;

   always_comb begin
      sr    = inv_shift_rows(state);
      sb    = '0;
      mixed = '0;
      for (int i = 0; i < 16; i++)
         sb[127-8*i -: 8] = INV_SBOX[sr[127-8*i -: 8]];
      ark = sb ^ roundKey;
      for (int c = 0; c < 4; c++)
         mixed[127-32*c -: 32] = inv_mix_column(ark[127-32*c -: 32]);
      next = last ? ark : mixed;
   end

endmodule

// File: rtl/aes_inv_cipher.sv
// rtl/aes_inv_cipher.sv - iterative AES-128 decryption, one round per clock
// Ports: clk, rst (async, active-high), bus (aes_inv_cipher_if.slave):
//        start/iBlock in, roundKey in (combinational from round), round out,
//        oBlock out (held until next completion), idle out, done out (1-cycle pulse).
module aes_inv_cipher
   import aes_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   aes_inv_cipher_if.slave  bus
);

   state_t       st;
   logic [3:0]   cnt;
   logic [127:0] sreg;
   logic [127:0] oreg;
   logic         done_r;
   logic [127:0] nxt;

   // The key store is addressed directly; key 10 is presented while idle so
   // the initial AddRoundKey can happen on the accepting edge.
   assign bus.round  = (st == S_IDLE) ? 4'(NR) : cnt;
   assign bus.idle   = (st == S_IDLE);
   assign bus.oBlock = oreg;
   assign bus.done   = done_r;

   aes_inv_round u_round (
      .state    (sreg),
      .roundKey (bus.roundKey),
      .last     (cnt == 4'd0),
      .next     (nxt)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st     <= S_IDLE;
         cnt    <= 4'd0;
         sreg   <= '0;
         oreg   <= '0;
         done_r <= 1'b0;
      end else begin
         done_r <= 1'b0;
         case (st)
            S_IDLE: begin
               if (bus.start) begin
                  sreg <= bus.iBlock ^ bus.roundKey;
                  cnt  <= 4'(NR - 1);
                  st   <= S_RUN;
               end
            end
            S_RUN: begin
               if (cnt != 4'd0) begin
                  sreg <= nxt;
                  cnt  <= cnt - 4'd1;
               end else begin
                  oreg   <= nxt;
                  done_r <= 1'b1;
                  st     <= S_IDLE;
               end
            end
            default: st <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_cipher.sv
// tb/tb_aes_inv_cipher.sv - self-checking bench for aes_inv_cipher
// Ports: none; drives the DUT through aes_inv_cipher_if and serves round keys
//        from its own expanded key table.
module tb_aes_inv_cipher;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   aes_inv_cipher_if bus ();

   aes_inv_cipher dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   logic [127:0] rk [16];
   logic [7:0]   sbox [256];
   int checks = 0;
   int errors = 0;

   assign bus.roundKey = rk[bus.round];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p ^= x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // Forward S-box from its definition: multiplicative inverse then affine map.
   task automatic build_sbox();
      logic [7:0] inv;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]} ^ {rc, 24'h0};
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      for (int r = 11; r < 16; r++) rk[r] = '0;
   endtask

   // Plain FIPS-197 forward cipher over a byte array, using the current rk table.
   function automatic logic [127:0] encrypt(input logic [127:0] pt);
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [127:0] o;
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ rk[0][127-8*i -: 8];
      for (int rnd = 1; rnd <= 10; rnd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r+4*c] = s[r+4*((c+r)%4)];
         if (rnd != 10) begin
            for (int c = 0; c < 4; c++) begin
               s[4*c]   = gf_mul(t[4*c],8'h02) ^ gf_mul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
               s[4*c+1] = t[4*c] ^ gf_mul(t[4*c+1],8'h02) ^ gf_mul(t[4*c+2],8'h03) ^ t[4*c+3];
               s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gf_mul(t[4*c+2],8'h02) ^ gf_mul(t[4*c+3],8'h03);
               s[4*c+3] = gf_mul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gf_mul(t[4*c+3],8'h02);
            end
         end else begin
            for (int i = 0; i < 16; i++) s[i] = t[i];
         end
         for (int i = 0; i < 16; i++) s[i] ^= rk[rnd][127-8*i -: 8];
      end
      for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[i];
      return o;
   endfunction

   // Called at posedge+1 with the DUT idle; pulses start and waits for done.
   task automatic do_block(input logic [127:0] ct, input logic [127:0] pt,
                           input string tag, input bit chk_rounds);
      int k;
      bit seen;
      if (chk_rounds) check({tag, "_round_idle"}, 128'(bus.round), 128'd10);
      bus.iBlock = ct;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      k = 0;
      seen = 1'b0;
      while (!seen && k < 20) begin
         if (chk_rounds && k <= 9) check({tag, "_round"}, 128'(bus.round), 128'(9 - k));
         @(posedge clk); #1;
         k++;
         if (bus.done) seen = 1'b1;
      end
      check({tag, "_latency"}, 128'(k + 1), 128'd11);
      check({tag, "_result"}, bus.oBlock, pt);
      check({tag, "_idle_at_done"}, 128'(bus.idle), 128'd1);
      @(posedge clk); #1;
      check({tag, "_done_single"}, 128'(bus.done), 128'd0);
   endtask

   initial begin
      int k, t, t1, t2, dones;
      bit stable, idle_ok;
      logic [127:0] key, pt;

      rst = 1'b1;
      bus.start = 1'b0;
      bus.iBlock = '0;
      build_sbox();
      expand(C1_KEY);
      repeat (3) @(posedge clk);
      #1;
      check("rst_idle", 128'(bus.idle), 128'd1);
      check("rst_done", 128'(bus.done), 128'd0);
      check("rst_oblock", bus.oBlock, 128'd0);
      check("rst_round", 128'(bus.round), 128'd10);
      rst = 1'b0;
      @(posedge clk); #1;

      do_block(C1_CT, C1_PT, "c1", 1'b0);

      expand(B_KEY);
      do_block(B_CT, B_PT, "appb", 1'b1);

      // Busy start: a second request during RUN must be ignored.
      expand(C1_KEY);
      bus.iBlock = C1_CT;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      idle_ok = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (bus.idle !== 1'b0) idle_ok = 1'b0;
         if (i == 4) begin bus.start = 1'b1; bus.iBlock = B_CT; end
         if (i == 5) bus.start = 1'b0;
         @(posedge clk); #1;
      end
      check("busy_idle_low", 128'(idle_ok), 128'd1);
      check("busy_done", 128'(bus.done), 128'd1);
      check("busy_result", bus.oBlock, C1_PT);
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      check("busy_no_restart", 128'(dones), 128'd0);

      // Reset during RUN cycle 4.
      bus.iBlock = C1_CT;
      bus.start  = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (3) begin @(posedge clk); #1; end
      rst = 1'b1;
      #1;
      check("midrst_idle", 128'(bus.idle), 128'd1);
      check("midrst_oblock", bus.oBlock, 128'd0);
      check("midrst_round", 128'(bus.round), 128'd10);
      @(posedge clk); #1;
      rst = 1'b0;
      dones = 0;
      for (int i = 0; i < 12; i++) begin
         @(posedge clk); #1;
         if (bus.done) dones++;
      end
      check("midrst_no_done", 128'(dones), 128'd0);
      check("midrst_oblock_hold", bus.oBlock, 128'd0);
      do_block(C1_CT, C1_PT, "after_rst", 1'b0);

      // Held start across two blocks; key store swapped in the done cycle.
      expand(C1_KEY);
      bus.iBlock = C1_CT;
      bus.start  = 1'b1;
      t = 0; t1 = 0; t2 = 0; stable = 1'b1;
      while (t2 == 0 && t < 40) begin
         @(posedge clk); #1;
         t++;
         if (bus.done) begin
            if (t1 == 0) begin
               t1 = t;
               check("held_c1", bus.oBlock, C1_PT);
               expand(B_KEY);
               bus.iBlock = B_CT;
            end else begin
               t2 = t;
               bus.start = 1'b0;
               check("held_b", bus.oBlock, B_PT);
            end
         end else if (t1 != 0 && bus.oBlock !== C1_PT) begin
            stable = 1'b0;
         end
      end
      bus.start = 1'b0;
      check("held_first_latency", 128'(t1), 128'd11);
      check("held_gap", 128'(t2 - t1), 128'd11);
      check("held_stable", 128'(stable), 128'd1);
      @(posedge clk); #1;
      check("held_stops", 128'(bus.idle), 128'd1);

      // Round trip against the bench's own forward cipher.
      for (int n = 0; n < 100; n++) begin
         key = {$urandom, $urandom, $urandom, $urandom};
         pt  = {$urandom, $urandom, $urandom, $urandom};
         expand(key);
         do_block(encrypt(pt), pt, "rt", (n % 25) == 0);
      end

      k = 0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/aes_inv_cipher.md
# aes_inv_cipher

Iterative AES-128 inverse cipher (FIPS-197 decryption) that computes one round per clock. It is the decrypt counterpart of the existing encrypt datapath and sits beside it under the top-level core. Round keys come from the shared key-expansion block, which the cipher addresses in reverse order (10 down to 0). The block only decrypts; key loading and expansion are owned by the key-expansion block.

## Interface
- No parameters. Fixed AES-128, Nr = 10.
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- start  in  1  request decryption of iBlock; sampled only while idle
- roundKey  in  128  round key selected by round; combinational read from key store, valid in the same cycle round is driven
- iBlock  in  128  ciphertext; bits [127:120] are state byte 0, column-major
- round  out  4  round-key index requested from key expansion
- oBlock  out  128  plaintext; holds the last result until the next completion
- idle  out  1  high when ready to accept start
- done  out  1  one-cycle pulse when oBlock updates

## Operation
- States: IDLE, RUN.
- IDLE:
  - round = 10.
  - On start: state register <= iBlock ^ roundKey (initial AddRoundKey with key 10), counter <= 9, go to RUN.
- RUN with counter c in 9..1:
  - round = c.
  - state <= InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ roundKey).
  - c <= c-1.
- RUN with c = 0:
  - round = 0.
  - oBlock <= InvSubBytes(InvShiftRows(state)) ^ roundKey.
  - done <= 1, go to IDLE.
- InvMixColumns uses GF(2^8) multiplication by 0e/0b/0d/09 with polynomial 0x11b, built from xtime chains, not multipliers.
- start while in RUN is ignored; iBlock is not re-sampled.
- start held high continuously starts a new block on the first IDLE cycle after completion. Back-to-back throughput is one block per 11 cycles.
- The key store must not be reloaded during RUN. If it is, the result is undefined but the FSM must still return to IDLE after 10 RUN cycles.

## Timing
- Reset values: state IDLE, counter 0, state register 0, oBlock 0, done 0, idle 1, round 10.
- idle is combinational from the state (IDLE → 1). It drops the cycle after start is sampled.
- Latency: start sampled at edge E0. The round-9..1 updates occur at E1..E9. The final round occurs at E10. oBlock is valid and done = 1 in the cycle after E10, with idle = 1 in that same cycle.
- round is combinational from state and counter. roundKey must settle in the same cycle; there are no registered key stages.
- rst asserted mid-RUN returns to reset values immediately. done is not pulsed and oBlock reads 0.

## Structure
- Shared package aes_pkg:
  - state enum.
  - 256-entry inverse S-box constant.
  - Functions xtime, gmul09/0b/0d/0e, inv_shift_rows, inv_mix_column.
  - Constant NR = 10.
- Sub-module aes_inv_round: combinational. Inputs are state, roundKey, and a final flag. Output is the next state (InvShiftRows → InvSubBytes → AddRoundKey → InvMixColumns unless final).
- aes_inv_cipher holds the FSM, the counter, the state register, and the oBlock register.
- Key expansion is instantiated in the core, not here.

## Test plan
- FIPS-197 C.1:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f, iBlock 69c4e0d86a7b0430d8cdb78070b4c55a, start pulse.
  - Required response: oBlock = 00112233445566778899aabbccddeeff exactly 11 cycles after start, with one done pulse.
- FIPS-197 Appendix B:
  - Stimulus: key 2b7e151628aed2a6abf7158809cf4f3c, iBlock 3925841d02dc09fbdc118597196a0b32.
  - Required response: oBlock = 3243f6a8885a308d313198a2e0370734.
  - Check: round sequence observed is 10, 9, …, 0.
- Busy start:
  - Stimulus: second start with a different iBlock at cycle 5 of RUN.
  - Required response: ignored; result equals the first block; idle stays 0 for 10 cycles.
- Reset mid-operation:
  - Stimulus: rst asserted at RUN cycle 4.
  - Required response: idle = 1, oBlock = 0, no done pulse. A subsequent C.1 run still produces the correct plaintext.
- Held start:
  - Stimulus: start held high for two blocks (C.1 then B ciphertext, same key store reloaded between runs while idle).
  - Required response: both results correct, done pulses 11 cycles apart, oBlock stable between pulses.
- Round-trip:
  - Stimulus: 100 random key/plaintext pairs encrypted by the existing encrypt datapath, then fed to this block.
  - Required response: every output equals its original plaintext.
